// File: rtl/note_pkg.sv
// Shared definitions for the polyphonic note player: note table,
// half-period lookup and the channel state encoding.
package note_pkg;

    localparam int NOTE_COUNT = 28;
    localparam int HALF_W     = 21;

    typedef logic [HALF_W-1:0] half_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } ch_state_t;

    // Half period in clocks for note indices 1..28 (low to high pitch).
    localparam half_t NOTE_HALF [1:NOTE_COUNT] = '{
        21'd95565, 21'd85120, 21'd75849, 21'd71591, 21'd63775, 21'd56817, 21'd50617,
        21'd47773, 21'd42567, 21'd37918, 21'd35790, 21'd31887, 21'd28408, 21'd25308,
        21'd23820, 21'd21281, 21'd18960, 21'd17896, 21'd15943, 21'd14204, 21'd12654,
        21'd11949, 21'd10633, 21'd9483,  21'd8947,  21'd7971,  21'd7101,  21'd6324
    };

    // Zero means "rest": the channel stays silent but still counts beats.
    function automatic half_t note_half(input int unsigned idx);
        half_t half;
        half = '0;
        if (idx >= 1 && idx <= NOTE_COUNT) begin
            half = NOTE_HALF[idx[4:0]];
        end
        return half;
    endfunction

endpackage

// File: rtl/poly_note_player_if.sv
// Command/status bundle between the melody sequencer (master) and the
// note player (slave). Buses are packed per channel.
interface poly_note_player_if #(
    parameter int CHANNELS = 2,
    parameter int NOTE_W   = 5,
    parameter int DUR_W    = 8
) ();
    logic                       tick;
    logic [CHANNELS-1:0]        note_valid;
    logic [CHANNELS-1:0]        note_ready;
    logic [CHANNELS*NOTE_W-1:0] note_idx;
    logic [CHANNELS*DUR_W-1:0]  note_dur;
    logic [CHANNELS-1:0]        stop;
    logic [CHANNELS-1:0]        busy;
    logic [CHANNELS-1:0]        done;
    logic [CHANNELS-1:0]        beep;
    logic                       beep_mix;

    modport master (
        output tick, note_valid, note_idx, note_dur, stop,
        input  note_ready, busy, done, beep, beep_mix
    );

    modport slave (
        input  tick, note_valid, note_idx, note_dur, stop,
        output note_ready, busy, done, beep, beep_mix
    );
endinterface

// File: rtl/note_channel.sv
// One tone channel: IDLE/PLAY FSM, half-period counter, beat counter
// and the square-wave output flop.
module note_channel
    import note_pkg::*;
#(
    parameter int NOTE_W = 5,
    parameter int CNT_W  = 21,
    parameter int DUR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              valid,
    output logic              ready,
    input  logic [NOTE_W-1:0] idx,
    input  logic [DUR_W-1:0]  dur,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              beep
);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] half_q, cnt_q;
    logic [DUR_W-1:0] rem_q;
    logic             beep_q, done_q;
    logic             last_beat;

    assign last_beat = tick && (rem_q == DUR_W'(1));

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; stop wins over a coincident final tick.
    // NOTE: the default comes first so no path leaves state_d unassigned
    // (which would infer a latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid) state_d = PLAY;
            PLAY:    if (stop || last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: latch the command, run the tone and beat counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q <= '0;
            cnt_q  <= '0;
            rem_q  <= '0;
            beep_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        half_q <= CNT_W'(note_half(32'(idx)));
                        rem_q  <= (dur == '0) ? DUR_W'(1) : dur;
                        cnt_q  <= '0;
                        beep_q <= 1'b0;
                    end
                end
                PLAY: begin
                    if (stop) begin
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        beep_q <= 1'b0;
                    end else if (last_beat) begin
                        cnt_q  <= '0;
                        rem_q  <= '0;
                        beep_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        if (tick) rem_q <= rem_q - DUR_W'(1);
                        if (half_q == '0) begin
                            cnt_q  <= '0;
                            beep_q <= 1'b0;
                        end else if (cnt_q == half_q - CNT_W'(1)) begin
                            cnt_q  <= '0;
                            beep_q <= ~beep_q;
                        end else begin
                            cnt_q  <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == PLAY);
    assign done  = done_q;
    assign beep  = beep_q;

endmodule

// File: rtl/poly_note_player.sv
// Multi-channel note player: CHANNELS independent tone channels sharing
// one beat strobe, plus a registered XOR mix of all channel outputs.
module poly_note_player
    import note_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int NOTE_W   = 5,
    parameter int CNT_W    = 21,
    parameter int DUR_W    = 8
) (
    input logic              clk,
    input logic              rst_n,
    poly_note_player_if.slave bus
);

    logic [CHANNELS-1:0] ready, busy, done, beep;
    logic                mix_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        note_channel #(
            .NOTE_W (NOTE_W),
            .CNT_W  (CNT_W),
            .DUR_W  (DUR_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (bus.tick),
            .valid (bus.note_valid[g]),
            .ready (ready[g]),
            .idx   (bus.note_idx[g*NOTE_W +: NOTE_W]),
            .dur   (bus.note_dur[g*DUR_W +: DUR_W]),
            .stop  (bus.stop[g]),
            .busy  (busy[g]),
            .done  (done[g]),
            .beep  (beep[g])
        );
    end

    // Mixed output: one clock behind the per-channel beeps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mix_q <= 1'b0;
        else        mix_q <= ^beep;
    end

    assign bus.note_ready = ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.beep       = beep;
    assign bus.beep_mix   = mix_q;

endmodule

// File: tb/tb_poly_note_player.sv
// Bench for poly_note_player: a cycle-level reference model built from the
// note rules runs alongside the DUT; scenario tasks drive commands and check.
module tb_poly_note_player;

    localparam int CH = 2;
    localparam int NW = 5;
    localparam int DW = 8;
    localparam int CW = 21;

    logic clk;
    logic rst_n;

    poly_note_player_if #(.CHANNELS(CH), .NOTE_W(NW), .DUR_W(DW)) bus ();

    poly_note_player #(.CHANNELS(CH), .NOTE_W(NW), .CNT_W(CW), .DUR_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mon_err = 0;

    // Reference table: half period for each index, 0 = rest.
    int unsigned tab [0:28] = '{0,
        95565, 85120, 75849, 71591, 63775, 56817, 50617, 47773, 42567, 37918,
        35790, 31887, 28408, 25308, 23820, 21281, 18960, 17896, 15943, 14204,
        12654, 11949, 10633, 9483, 8947, 7971, 7101, 6324};

    function automatic int unsigned ref_half(input int unsigned idx);
        return (idx <= 28) ? tab[idx] : 0;
    endfunction

    // Model state: edge counter, per-channel start edge, half period, beats left.
    int unsigned cyc;
    bit          m_play [CH];
    bit          m_done [CH];
    int unsigned m_start[CH];
    int unsigned m_half [CH];
    int unsigned m_rem  [CH];
    bit          m_mix;

    // Square wave starts low at the accept edge and flips every HALF edges.
    function automatic bit exp_beep(input int c);
        if (!m_play[c] || m_half[c] == 0) return 1'b0;
        return (((cyc - m_start[c]) / m_half[c]) % 2) == 1;
    endfunction

    function automatic bit exp_mix();
        bit x = 1'b0;
        for (int c = 0; c < CH; c++) x ^= exp_beep(c);
        return x;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc   = 0;
            m_mix = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_play[c] = 0; m_done[c] = 0; m_start[c] = 0; m_half[c] = 0; m_rem[c] = 0;
            end
        end else begin
            m_mix = exp_mix();
            cyc++;
            for (int c = 0; c < CH; c++) begin
                m_done[c] = 1'b0;
                if (!m_play[c]) begin
                    if (bus.note_valid[c]) begin
                        m_play[c]  = 1'b1;
                        m_start[c] = cyc;
                        m_half[c]  = ref_half(bus.note_idx[c*NW +: NW]);
                        m_rem[c]   = (bus.note_dur[c*DW +: DW] == 0) ? 1 : bus.note_dur[c*DW +: DW];
                    end
                end else if (bus.stop[c]) begin
                    m_play[c] = 1'b0;
                end else if (bus.tick) begin
                    if (m_rem[c] == 1) begin
                        m_play[c] = 1'b0;
                        m_done[c] = 1'b1;
                    end else begin
                        m_rem[c]--;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model; scenarios check the tally.
    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (bus.beep[c]       !== exp_beep(c)) mon_err++;
            if (bus.note_ready[c] !== !m_play[c])  mon_err++;
            if (bus.busy[c]       !== m_play[c])   mon_err++;
            if (bus.done[c]       !== m_done[c])   mon_err++;
        end
        if (bus.beep_mix !== m_mix) mon_err++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input int c, input int idx, input int dur, output bit ok);
        ok = 1'b0;
        bus.note_idx[c*NW +: NW] = NW'(idx);
        bus.note_dur[c*DW +: DW] = DW'(dur);
        bus.note_valid[c] = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = bus.note_ready[c];
            step();
        end
        bus.note_valid[c] = 1'b0;
    endtask

    task automatic test_reset();
        step();
        checks++; if (bus.note_ready !== '1) begin errors++; $display("FAIL reset_ready got %b want 11", bus.note_ready); end
        checks++; if (bus.busy !== '0) begin errors++; $display("FAIL reset_busy got %b want 00", bus.busy); end
        checks++; if (bus.done !== '0) begin errors++; $display("FAIL reset_done got %b want 00", bus.done); end
        checks++; if (bus.beep !== '0) begin errors++; $display("FAIL reset_beep got %b want 00", bus.beep); end
        checks++; if (bus.beep_mix !== 1'b0) begin errors++; $display("FAIL reset_mix got %b want 0", bus.beep_mix); end
    endtask

    task automatic test_tone();
        bit ok;
        int p = $urandom_range(4000, 4500);
        int n = 0;
        int first_rise = -1;
        mon_err = 0;
        issue(0, 28, 2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL tone_accept got 0 want 1"); end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < p; i++) begin
                if (i == p - 1) bus.tick = 1'b1;
                step(); n++;
                bus.tick = 1'b0;
                if (first_rise < 0 && bus.beep[0] === 1'b1) first_rise = n;
            end
        end
        checks++; if (first_rise != 6324) begin errors++; $display("FAIL tone_first_rise got %0d want 6324", first_rise); end
        checks++; if (bus.done[0] !== 1'b1) begin errors++; $display("FAIL tone_done got %b want 1", bus.done[0]); end
        checks++; if (bus.busy[0] !== 1'b0 || bus.beep[0] !== 1'b0) begin errors++; $display("FAIL tone_end busy/beep got %b%b want 00", bus.busy[0], bus.beep[0]); end
        step();
        checks++; if (bus.done[0] !== 1'b0) begin errors++; $display("FAIL tone_done_len got %b want 0", bus.done[0]); end
        checks++; if (mon_err != 0) begin errors++; $display("FAIL tone_model got %0d mismatches want 0", mon_err); end
    endtask

    task automatic test_rest();
        bit ok;
        int bad = 0;
        int p = $urandom_range(200, 400);
        mon_err = 0;
        issue(0, 0, 3, ok);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < p; i++) begin
                if (bus.beep[0] !== 1'b0 || bus.busy[0] !== 1'b1) bad++;
                if (i == p - 1) bus.tick = 1'b1;
                step();
                bus.tick = 1'b0;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rest_silent got %0d bad cycles want 0", bad); end
        checks++; if (bus.done[0] !== 1'b1 || bus.busy[0] !== 1'b0) begin errors++; $display("FAIL rest_done done/busy got %b%b want 10", bus.done[0], bus.busy[0]); end
        step();
        checks++; if (mon_err != 0) begin errors++; $display("FAIL rest_model got %0d mismatches want 0", mon_err); end
    endtask

    task automatic test_two_channels();
        int p = $urandom_range(3800, 4200);
        int n = 0;
        int rise0 = -1;
        int rise1 = -1;
        mon_err = 0;
        checks++; if (bus.note_ready !== 2'b11) begin errors++; $display("FAIL dual_ready got %b want 11", bus.note_ready); end
        bus.note_idx = {NW'(28), NW'(27)};
        bus.note_dur = {DW'(2), DW'(2)};
        bus.note_valid = 2'b11;
        step();
        bus.note_valid = 2'b00;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < p; i++) begin
                if (i == p - 1) bus.tick = 1'b1;
                step(); n++;
                bus.tick = 1'b0;
                if (rise0 < 0 && bus.beep[0] === 1'b1) rise0 = n;
                if (rise1 < 0 && bus.beep[1] === 1'b1) rise1 = n;
            end
        end
        checks++; if (rise0 != 7101) begin errors++; $display("FAIL dual_rise0 got %0d want 7101", rise0); end
        checks++; if (rise1 != 6324) begin errors++; $display("FAIL dual_rise1 got %0d want 6324", rise1); end
        checks++; if (bus.done !== 2'b11) begin errors++; $display("FAIL dual_done got %b want 11", bus.done); end
        step();
        checks++; if (mon_err != 0) begin errors++; $display("FAIL dual_model got %0d mismatches want 0", mon_err); end
    endtask

    task automatic test_stop();
        bit ok;
        mon_err = 0;
        issue(0, $urandom_range(1, 28), 1, ok);
        repeat (999) step();
        bus.tick = 1'b1;
        bus.stop[0] = 1'b1;
        step();
        bus.tick = 1'b0;
        bus.stop[0] = 1'b0;
        checks++; if (bus.done[0] !== 1'b0) begin errors++; $display("FAIL stop_no_done got %b want 0", bus.done[0]); end
        checks++; if (bus.busy[0] !== 1'b0 || bus.note_ready[0] !== 1'b1) begin errors++; $display("FAIL stop_idle busy/ready got %b%b want 01", bus.busy[0], bus.note_ready[0]); end
        checks++; if (bus.beep[0] !== 1'b0) begin errors++; $display("FAIL stop_beep got %b want 0", bus.beep[0]); end
        step();
        checks++; if (mon_err != 0) begin errors++; $display("FAIL stop_model got %0d mismatches want 0", mon_err); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int p = $urandom_range(150, 300);
        mon_err = 0;
        issue(1, $urandom_range(1, 28), 2, ok);
        bus.note_idx[NW +: NW] = NW'($urandom_range(1, 28));
        bus.note_dur[DW +: DW] = '0;
        bus.note_valid[1] = 1'b1;
        for (int b = 0; b < 2; b++) begin
            repeat (p - 1) step();
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
        end
        checks++; if (bus.done[1] !== 1'b1 || bus.note_ready[1] !== 1'b1) begin errors++; $display("FAIL b2b_end done/ready got %b%b want 11", bus.done[1], bus.note_ready[1]); end
        step();
        bus.note_valid[1] = 1'b0;
        checks++; if (bus.busy[1] !== 1'b1 || bus.done[1] !== 1'b0) begin errors++; $display("FAIL b2b_accept busy/done got %b%b want 10", bus.busy[1], bus.done[1]); end
        repeat (50) step();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        checks++; if (bus.done[1] !== 1'b1 || bus.busy[1] !== 1'b0) begin errors++; $display("FAIL b2b_dur0 done/busy got %b%b want 10", bus.done[1], bus.busy[1]); end
        step();
        checks++; if (mon_err != 0) begin errors++; $display("FAIL b2b_model got %0d mismatches want 0", mon_err); end
    endtask

    task automatic test_random();
        bit acc [CH];
        mon_err = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (!bus.note_valid[c] && $urandom_range(0, 40) == 0) begin
                    bus.note_idx[c*NW +: NW] = NW'($urandom_range(0, 31));
                    bus.note_dur[c*DW +: DW] = DW'($urandom_range(0, 3));
                    bus.note_valid[c] = 1'b1;
                end
                bus.stop[c] = ($urandom_range(0, 150) == 0);
                acc[c] = bus.note_valid[c] && bus.note_ready[c];
            end
            bus.tick = ($urandom_range(0, 60) == 0);
            step();
            for (int c = 0; c < CH; c++) if (acc[c]) bus.note_valid[c] = 1'b0;
        end
        bus.tick = 1'b0;
        bus.stop = '1;
        bus.note_valid = '0;
        step();
        bus.stop = '0;
        step();
        checks++; if (mon_err != 0) begin errors++; $display("FAIL random_model got %0d mismatches want 0", mon_err); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int n = 0;
        int rise = -1;
        mon_err = 0;
        issue(0, 28, 5, ok);
        repeat (7000) step();
        checks++; if (bus.beep[0] !== 1'b1) begin errors++; $display("FAIL areset_pre_beep got %b want 1", bus.beep[0]); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (bus.beep !== '0 || bus.busy !== '0) begin errors++; $display("FAIL areset_outputs beep/busy got %b/%b want 00/00", bus.beep, bus.busy); end
        checks++; if (bus.note_ready !== '1) begin errors++; $display("FAIL areset_ready got %b want 11", bus.note_ready); end
        step();
        rst_n = 1'b1;
        step();
        issue(0, 9, 1, ok);
        while (rise < 0 && n < 43000) begin
            step(); n++;
            if (bus.beep[0] === 1'b1) rise = n;
        end
        checks++; if (rise != 42567) begin errors++; $display("FAIL areset_idx9_rise got %0d want 42567", rise); end
        bus.stop[0] = 1'b1;
        step();
        bus.stop[0] = 1'b0;
        step();
        checks++; if (mon_err != 0) begin errors++; $display("FAIL areset_model got %0d mismatches want 0", mon_err); end
    endtask

    initial begin
        rst_n = 1'b1;
        bus.tick = 1'b0;
        bus.note_valid = '0;
        bus.note_idx = '0;
        bus.note_dur = '0;
        bus.stop = '0;
        #1 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        test_reset();
        test_tone();
        test_rest();
        test_two_channels();
        test_stop();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
